// File: rtl/mca_ctrl_sequencer_if.sv
// Handshake bundle between the control-bit source / accumulator side and
// mca_ctrl_sequencer. The master side feeds samples and housekeeping strobes,
// and the slave side (the sequencer) returns the snapshot and status flags.
interface mca_ctrl_sequencer_if #(
  parameter int NUM_ADDITIONS = 16
);

  logic                     enable;
  logic                     in_valid;
  logic                     in_bit;
  logic                     clear_overrun;
  logic                     start;
  logic [NUM_ADDITIONS-1:0] S_values;
  logic                     busy;
  logic                     primed;
  logic                     overrun;

  modport master (
    output enable,
    output in_valid,
    output in_bit,
    output clear_overrun,
    input  start,
    input  S_values,
    input  busy,
    input  primed,
    input  overrun
  );

  modport slave (
    input  enable,
    input  in_valid,
    input  in_bit,
    input  clear_overrun,
    output start,
    output S_values,
    output busy,
    output primed,
    output overrun
  );

endinterface

// File: rtl/mca_ctrl_sequencer.sv
// Upstream sequencer for the multi-cycle add/sub accumulator. It shifts in one
// CBADC control bit per accepted sample and keeps the newest NUM_ADDITIONS bits.
// Every DOWNSAMPLE full-buffer samples it freezes the buffer onto S_values and
// pulses start. The snapshot is then held for the ADD_CYCLES-long adding window.
// A snapshot that falls due while that window is still open is dropped, and the
// sticky overrun flag records the drop.
module mca_ctrl_sequencer #(
  parameter int NUM_ADDITIONS = 16,
  parameter int DOWNSAMPLE    = 32,
  parameter int ADD_CYCLES    = 17
) (
  input  logic                  clk,
  input  logic                  resetn,
  mca_ctrl_sequencer_if.slave   bus
);

  localparam int FILL_W = $clog2(NUM_ADDITIONS + 1);
  localparam int DS_W   = (DOWNSAMPLE > 1) ? $clog2(DOWNSAMPLE) : 1;
  localparam int BC_W   = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_ADDITIONS);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_ADDITIONS - 1);
  localparam logic [DS_W-1:0]   DS_LAST   = DS_W'(DOWNSAMPLE - 1);
  localparam logic [BC_W-1:0]   BC_LOAD   = BC_W'(ADD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t                   state_q,    state_d;
  logic [NUM_ADDITIONS-1:0] shreg_q,    shreg_d;
  logic [FILL_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic [DS_W-1:0]          ds_cnt_q,   ds_cnt_d;
  logic [BC_W-1:0]          busy_cnt_q, busy_cnt_d;
  logic                     start_q,    start_d;
  logic [NUM_ADDITIONS-1:0] s_values_q, s_values_d;
  logic                     busy_q,     busy_d;
  logic                     primed_q,   primed_d;
  logic                     overrun_q,  overrun_d;

  logic                     accept;
  logic                     buffer_full;
  logic                     ds_wrap;
  logic                     trigger;
  logic                     launch;
  logic                     drop;
  logic [NUM_ADDITIONS-1:0] shreg_shift;

  // Decode this cycle's sample and determine whether it completes a snapshot period.
  always_comb begin
    accept      = bus.enable & bus.in_valid;
    buffer_full = (fill_cnt_q >= FILL_LAST);
    ds_wrap     = (ds_cnt_q == DS_LAST);
    trigger     = accept & buffer_full & ds_wrap;
    launch      = trigger & (state_q != ST_BUSY);
    drop        = trigger & (state_q == ST_BUSY);
    shreg_shift = {shreg_q[NUM_ADDITIONS-2:0], bus.in_bit};
  end

  // Next-state logic for the buffer, the counters, the FSM and the registered outputs.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    fill_cnt_d = fill_cnt_q;
    ds_cnt_d   = ds_cnt_q;
    busy_cnt_d = busy_cnt_q;
    start_d    = start_q;
    s_values_d = s_values_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;

    if (bus.enable) begin
      start_d = 1'b0;

      if (accept) begin
        shreg_d = shreg_shift;
        if (fill_cnt_q != FILL_FULL) begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end
        if (buffer_full) begin
          ds_cnt_d = ds_wrap ? '0 : ds_cnt_q + DS_W'(1);
        end
      end

      if (bus.clear_overrun) begin
        overrun_d = 1'b0;
      end

      case (state_q)
        ST_FILL: begin
          if (!launch && (fill_cnt_d == FILL_FULL)) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_BUSY: begin
          if (busy_cnt_q == '0) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            busy_cnt_d = busy_cnt_q - BC_W'(1);
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase

      if (drop) begin
        overrun_d = 1'b1;
      end

      if (launch) begin
        s_values_d = shreg_shift;
        start_d    = 1'b1;
        busy_d     = 1'b1;
        busy_cnt_d = BC_LOAD;
        state_d    = ST_BUSY;
      end
    end

    primed_d = (fill_cnt_d == FILL_FULL);
  end

  // State register; every flop returns to its idle value on an asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_FILL;
      shreg_q    <= '0;
      fill_cnt_q <= '0;
      ds_cnt_q   <= DS_LAST;
      busy_cnt_q <= '0;
      start_q    <= 1'b0;
      s_values_q <= '0;
      busy_q     <= 1'b0;
      primed_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      fill_cnt_q <= fill_cnt_d;
      ds_cnt_q   <= ds_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      start_q    <= start_d;
      s_values_q <= s_values_d;
      busy_q     <= busy_d;
      primed_q   <= primed_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.start    = start_q;
  assign bus.S_values = s_values_q;
  assign bus.busy     = busy_q;
  assign bus.primed   = primed_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_mca_ctrl_sequencer.sv
// Self-checking bench for mca_ctrl_sequencer. Two instances share the same
// stimulus: one has a 32-sample snapshot period and one has a 4-sample period,
// which forces overruns. Expected values are hand-derived from the sample index.
module tb_mca_ctrl_sequencer;

  logic clk;
  logic resetn;
  logic enable;
  logic in_valid;
  logic in_bit;
  logic clear_overrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] hist;
  logic [15:0] snap;

  typedef struct {
    logic        en;
    logic        vld;
    logic        bit_in;
    logic        clr;
    logic        e_start;
    logic        e_busy;
    logic        e_primed;
    logic        e_overrun;
    logic [15:0] e_s;
  } vec_t;

  vec_t vecs[$];

  mca_ctrl_sequencer_if #(.NUM_ADDITIONS(16)) if32 ();
  mca_ctrl_sequencer_if #(.NUM_ADDITIONS(16)) if4 ();

  assign if32.enable        = enable;
  assign if32.in_valid      = in_valid;
  assign if32.in_bit        = in_bit;
  assign if32.clear_overrun = clear_overrun;
  assign if4.enable         = enable;
  assign if4.in_valid       = in_valid;
  assign if4.in_bit         = in_bit;
  assign if4.clear_overrun  = clear_overrun;

  mca_ctrl_sequencer #(
    .NUM_ADDITIONS(16),
    .DOWNSAMPLE   (32),
    .ADD_CYCLES   (17)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (if32.slave)
  );

  mca_ctrl_sequencer #(
    .NUM_ADDITIONS(16),
    .DOWNSAMPLE   (4),
    .ADD_CYCLES   (17)
  ) dut4 (
    .clk   (clk),
    .resetn(resetn),
    .bus   (if4.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, then return shortly after the clock edge.
  task automatic applyStimulus(input logic en, input logic vld, input logic b, input logic clr);
    enable        = en;
    in_valid      = vld;
    in_bit        = b;
    clear_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs of one instance against the expected values.
  task automatic checkOutput(input string name, input bit sel,
                             input logic e_start, input logic e_busy,
                             input logic e_primed, input logic e_overrun,
                             input logic [15:0] e_s);
    logic [19:0] got;
    logic [19:0] exp;
    if (sel) got = {if4.start, if4.busy, if4.primed, if4.overrun, if4.S_values};
    else     got = {if32.start, if32.busy, if32.primed, if32.overrun, if32.S_values};
    exp = {e_start, e_busy, e_primed, e_overrun, e_s};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got start=%b busy=%b primed=%b overrun=%b S=%h, expected start=%b busy=%b primed=%b overrun=%b S=%h",
               name, got[19], got[18], got[17], got[16], got[15:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // Synchronous-looking reset pulse for both instances; clears the bench history too.
  task automatic applyReset();
    resetn        = 1'b0;
    enable        = 1'b0;
    in_valid      = 1'b0;
    in_bit        = 1'b0;
    clear_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    hist   = '0;
    snap   = '0;
  endtask

  initial begin
    logic [15:0] pattern;
    logic        b;
    logic        e_start;
    logic        e_busy;

    resetn        = 1'b0;
    enable        = 1'b0;
    in_valid      = 1'b0;
    in_bit        = 1'b0;
    clear_overrun = 1'b0;
    hist          = '0;
    snap          = '0;

    // Table for the A5C3 fill sequence, with stalled and idle cycles mixed in.
    pattern = 16'hA5C3;
    for (int k = 15; k >= 0; k--) begin
      vecs.push_back('{1'b1, 1'b1, pattern[k], 1'b0,
                       (k == 0), (k == 0), (k == 0), 1'b0,
                       (k == 0) ? 16'hA5C3 : 16'h0000});
      if (k == 12) vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
      if (k == 8)  vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
      if (k == 4)  vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    end
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA5C3});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA5C3});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA5C3});

    // Test 1: random inputs under reset, then five quiet cycles after release.
    for (int i = 0; i < 4; i++) begin
      {enable, in_valid, in_bit, clear_overrun} = 4'($urandom);
      @(posedge clk);
      #1;
      checkOutput($sformatf("t1_inreset%0d_d32", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("t1_inreset%0d_d4", i),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      checkOutput($sformatf("t1_post%0d_d32", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("t1_post%0d_d4", i),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end

    // Test 2: table-driven fill with 16'hA5C3, MSB first.
    applyReset();
    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r].en, vecs[r].vld, vecs[r].bit_in, vecs[r].clr);
      checkOutput($sformatf("t2_row%0d", r), 1'b0, vecs[r].e_start, vecs[r].e_busy,
                  vecs[r].e_primed, vecs[r].e_overrun, vecs[r].e_s);
    end

    // Test 3: continuous samples, eight 32-sample periods on the D=32 instance.
    applyReset();
    for (int i = 1; i <= 16 + 32 * 8; i++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[14:0], b};
      applyStimulus(1'b1, 1'b1, b, 1'b0);
      e_start = (i >= 16) && (((i - 16) % 32) == 0);
      e_busy  = (i >= 16) && (((i - 16) % 32) < 17);
      if (e_start) snap = hist;
      checkOutput($sformatf("t3_sample%0d", i), 1'b0, e_start, e_busy, (i >= 16), 1'b0, snap);
    end

    // Test 4: D=4 instance; triggers inside the busy window become overruns.
    applyReset();
    for (int i = 1; i <= 40; i++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[14:0], b};
      applyStimulus(1'b1, 1'b1, b, 1'b0);
      e_start = (i >= 16) && (((i - 16) % 20) == 0);
      e_busy  = (i >= 16) && (((i - 16) % 20) < 17);
      if (e_start) snap = hist;
      checkOutput($sformatf("t4_sample%0d", i), 1'b1, e_start, e_busy, (i >= 16), (i >= 20), snap);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_clear", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, snap);
    for (int i = 41; i <= 43; i++) begin
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      checkOutput($sformatf("t4_after_clear%0d", i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, snap);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_clear_vs_new_overrun", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, snap);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_clear_again", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, snap);

    // Test 5: enable dropped while start is high; start holds and busy stretches.
    applyReset();
    for (int i = 1; i <= 16; i++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[14:0], b};
      applyStimulus(1'b1, 1'b1, b, 1'b0);
      if (i == 16) snap = hist;
      checkOutput($sformatf("t5_fill%0d", i), 1'b0, (i == 16), (i == 16), (i == 16), 1'b0,
                  (i == 16) ? snap : 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      checkOutput($sformatf("t5_stall%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, snap);
    end
    for (int j = 17; j <= 48; j++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[14:0], b};
      applyStimulus(1'b1, 1'b1, b, 1'b0);
      if (j == 48) snap = hist;
      checkOutput($sformatf("t5_sample%0d", j), 1'b0, (j == 48), (j <= 32) || (j == 48),
                  1'b1, 1'b0, snap);
    end

    // Test 6: asynchronous reset in the middle of the busy window.
    applyReset();
    for (int i = 1; i <= 24; i++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[14:0], b};
      applyStimulus(1'b1, 1'b1, b, 1'b0);
      if (i == 16) snap = hist;
    end
    checkOutput("t6_busy_before_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, snap);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_async_reset_d32", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("t6_async_reset_d4",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    hist   = '0;
    snap   = '0;
    for (int i = 1; i <= 16; i++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[14:0], b};
      applyStimulus(1'b1, 1'b1, b, 1'b0);
      if (i == 16) snap = hist;
      checkOutput($sformatf("t6_refill%0d", i), 1'b0, (i == 16), (i == 16), (i == 16), 1'b0,
                  (i == 16) ? snap : 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
